// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus RISC datapath.
// A step register walks T0-T7 (plus RESET/HALT); every control line is decoded from that step and the opcode.
module control_sequencer #(
    parameter logic [4:0] ALU_ADD = 5'b00011,
    parameter logic [4:0] ALU_AND = 5'b00101,
    parameter logic [4:0] ALU_OR  = 5'b00110,
    parameter logic [4:0] ALU_INC = 5'b11111
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con,
    output logic        HiIn,
    output logic        LoIn,
    output logic        ZIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        MARIn,
    output logic        YIn,
    output logic        OPortIn,
    output logic        IRIn,
    output logic        HiSel,
    output logic        LoSel,
    output logic        ZHiSel,
    output logic        ZLoSel,
    output logic        PCSel,
    output logic        MDRSel,
    output logic        IPortSel,
    output logic        CSel,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        RIn,
    output logic        ROut,
    output logic        BAOut,
    output logic        ConIn,
    output logic        memread,
    output logic        memwrite,
    output logic [4:0]  ALUCode,
    output logic        run,
    output logic [3:0]  tstate
);

    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4,
        T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, S_RESET = 4'd8, S_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY, C_BR,
        C_JAL, C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_t;

    typedef struct packed {
        logic hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, y_in, oport_in, ir_in;
        logic hi_sel, lo_sel, zhi_sel, zlo_sel, pc_sel, mdr_sel, iport_sel, c_sel;
        logic gra, grb, grc, r_in, r_out, ba_out, con_in, mem_rd, mem_wr;
    } ctrl_t;

    state_t     state_q, state_d;
    op_class_t  op_class;
    state_t     last_step;
    ctrl_t      ctrl;
    logic [4:0] alu_code;
    logic [4:0] op;
    logic [4:0] imm_code;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];

    always_comb begin
        case (op) inside
            5'b00000:              op_class = C_LD;
            5'b00001:              op_class = C_LDI;
            5'b00010:              op_class = C_ST;
            [5'b00011:5'b01011]:   op_class = C_ALU;
            [5'b01100:5'b01110]:   op_class = C_IMM;
            5'b01111, 5'b10000:    op_class = C_MULDIV;
            5'b10001, 5'b10010:    op_class = C_UNARY;
            5'b10011:              op_class = C_BR;
            5'b10100:              op_class = C_JAL;
            5'b10101:              op_class = C_JR;
            5'b10110:              op_class = C_IN;
            5'b10111:              op_class = C_OUT;
            5'b11000:              op_class = C_MFHI;
            5'b11001:              op_class = C_MFLO;
            5'b11011:              op_class = C_HALT;
            default:               op_class = C_NOP;
        endcase
    end

    always_comb begin
        case (op_class)
            C_LD:                  last_step = T7;
            C_ALU, C_IMM, C_LDI:   last_step = T5;
            C_MULDIV, C_ST, C_BR:  last_step = T6;
            C_UNARY, C_JAL:        last_step = T4;
            default:               last_step = T3;
        endcase
    end

    always_comb begin
        case (op)
            5'b01100: imm_code = ALU_ADD;
            5'b01101: imm_code = ALU_AND;
            default:  imm_code = ALU_OR;
        endcase
    end

    // nop/undefined and halt are resolved at T2, where the opcode is first valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = T0;
            T0:      state_d = T1;
            T1:      state_d = T2;
            T2: begin
                if (op_class == C_HALT)      state_d = S_HALT;
                else if (op_class == C_NOP)  state_d = T0;
                else                         state_d = T3;
            end
            T3, T4, T5, T6: state_d = (state_q == last_step) ? T0 : state_t'(state_q + 4'd1);
            T7:      state_d = T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // NOTE: clear is asynchronous; since outputs decode state_q directly, they fall to 0 the moment it asserts.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_RESET;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaulting every output first keeps this block free of inferred latches.
        ctrl     = '0;
        alu_code = '0;
        case (state_q)
            T0: begin ctrl.pc_sel = 1'b1; ctrl.mar_in = 1'b1; ctrl.z_in = 1'b1; alu_code = ALU_INC; end
            T1: begin ctrl.mem_rd = 1'b1; ctrl.mdr_in = 1'b1; ctrl.zlo_sel = 1'b1; ctrl.pc_in = 1'b1; end
            T2: begin ctrl.mdr_sel = 1'b1; ctrl.ir_in = 1'b1; end
            T3, T4, T5, T6, T7: begin
                case (op_class)
                    C_ALU, C_IMM: begin
                        case (state_q)
                            T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin
                                ctrl.z_in = 1'b1;
                                if (op_class == C_IMM) begin
                                    ctrl.c_sel = 1'b1;
                                    alu_code   = imm_code;
                                end else begin
                                    ctrl.grc   = 1'b1;
                                    ctrl.r_out = 1'b1;
                                    alu_code   = op;
                                end
                            end
                            T5: begin ctrl.zlo_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_MULDIV: begin
                        case (state_q)
                            T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; alu_code = op; end
                            T5: begin ctrl.zlo_sel = 1'b1; ctrl.lo_in = 1'b1; end
                            T6: begin ctrl.zhi_sel = 1'b1; ctrl.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_UNARY: begin
                        case (state_q)
                            T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; alu_code = op; end
                            T4: begin ctrl.zlo_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_LD, C_LDI, C_ST: begin
                        case (state_q)
                            T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.c_sel = 1'b1; ctrl.z_in = 1'b1; alu_code = ALU_ADD; end
                            T5: begin
                                ctrl.zlo_sel = 1'b1;
                                if (op_class == C_LDI) begin
                                    ctrl.gra  = 1'b1;
                                    ctrl.r_in = 1'b1;
                                end else begin
                                    ctrl.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                if (op_class == C_LD) begin
                                    ctrl.mem_rd = 1'b1;
                                    ctrl.mdr_in = 1'b1;
                                end else if (op_class == C_ST) begin
                                    ctrl.gra    = 1'b1;
                                    ctrl.r_out  = 1'b1;
                                    ctrl.mem_wr = 1'b1;
                                end
                            end
                            T7: begin
                                if (op_class == C_LD) begin
                                    ctrl.mdr_sel = 1'b1;
                                    ctrl.gra     = 1'b1;
                                    ctrl.r_in    = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    C_BR: begin
                        case (state_q)
                            T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
                            T4: begin ctrl.pc_sel = 1'b1; ctrl.y_in = 1'b1; end
                            T5: begin ctrl.c_sel = 1'b1; ctrl.z_in = 1'b1; alu_code = ALU_ADD; end
                            T6: begin ctrl.zlo_sel = 1'b1; ctrl.pc_in = con; end
                            default: ;
                        endcase
                    end
                    C_JAL: begin
                        case (state_q)
                            T3: begin ctrl.pc_sel = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1; end
                            T4: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_JR:   if (state_q == T3) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    C_IN:   if (state_q == T3) begin ctrl.iport_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    C_OUT:  if (state_q == T3) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.oport_in = 1'b1; end
                    C_MFHI: if (state_q == T3) begin ctrl.hi_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    C_MFLO: if (state_q == T3) begin ctrl.lo_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign HiIn     = ctrl.hi_in;
    assign LoIn     = ctrl.lo_in;
    assign ZIn      = ctrl.z_in;
    assign PCIn     = ctrl.pc_in;
    assign MDRIn    = ctrl.mdr_in;
    assign MARIn    = ctrl.mar_in;
    assign YIn      = ctrl.y_in;
    assign OPortIn  = ctrl.oport_in;
    assign IRIn     = ctrl.ir_in;
    assign HiSel    = ctrl.hi_sel;
    assign LoSel    = ctrl.lo_sel;
    assign ZHiSel   = ctrl.zhi_sel;
    assign ZLoSel   = ctrl.zlo_sel;
    assign PCSel    = ctrl.pc_sel;
    assign MDRSel   = ctrl.mdr_sel;
    assign IPortSel = ctrl.iport_sel;
    assign CSel     = ctrl.c_sel;
    assign Gra      = ctrl.gra;
    assign Grb      = ctrl.grb;
    assign Grc      = ctrl.grc;
    assign RIn      = ctrl.r_in;
    assign ROut     = ctrl.r_out;
    assign BAOut    = ctrl.ba_out;
    assign ConIn    = ctrl.con_in;
    assign memread  = ctrl.mem_rd;
    assign memwrite = ctrl.mem_wr;
    assign ALUCode  = alu_code;
    assign run      = (state_q != S_HALT);
    assign tstate   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: each instruction is expanded into its expected micro-program
// (a list of per-step control words) and the DUT is compared against it cycle by cycle.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        con;
    logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel, IPortSel, CSel;
    logic Gra, Grb, Grc, RIn, ROut, BAOut, ConIn, memread, memwrite;
    logic [4:0] ALUCode;
    logic       run;
    logic [3:0] tstate;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .con(con),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .MARIn(MARIn),
        .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
        .HiSel(HiSel), .LoSel(LoSel), .ZHiSel(ZHiSel), .ZLoSel(ZLoSel), .PCSel(PCSel),
        .MDRSel(MDRSel), .IPortSel(IPortSel), .CSel(CSel),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut),
        .ConIn(ConIn), .memread(memread), .memwrite(memwrite),
        .ALUCode(ALUCode), .run(run), .tstate(tstate)
    );

    localparam logic [25:0] HI_IN     = 26'h1 << 25;
    localparam logic [25:0] LO_IN     = 26'h1 << 24;
    localparam logic [25:0] Z_IN      = 26'h1 << 23;
    localparam logic [25:0] PC_IN     = 26'h1 << 22;
    localparam logic [25:0] MDR_IN    = 26'h1 << 21;
    localparam logic [25:0] MAR_IN    = 26'h1 << 20;
    localparam logic [25:0] Y_IN      = 26'h1 << 19;
    localparam logic [25:0] OPORT_IN  = 26'h1 << 18;
    localparam logic [25:0] IR_IN     = 26'h1 << 17;
    localparam logic [25:0] HI_SEL    = 26'h1 << 16;
    localparam logic [25:0] LO_SEL    = 26'h1 << 15;
    localparam logic [25:0] ZHI_SEL   = 26'h1 << 14;
    localparam logic [25:0] ZLO_SEL   = 26'h1 << 13;
    localparam logic [25:0] PC_SEL    = 26'h1 << 12;
    localparam logic [25:0] MDR_SEL   = 26'h1 << 11;
    localparam logic [25:0] IPORT_SEL = 26'h1 << 10;
    localparam logic [25:0] C_SEL     = 26'h1 << 9;
    localparam logic [25:0] GRA       = 26'h1 << 8;
    localparam logic [25:0] GRB       = 26'h1 << 7;
    localparam logic [25:0] GRC       = 26'h1 << 6;
    localparam logic [25:0] R_IN      = 26'h1 << 5;
    localparam logic [25:0] R_OUT     = 26'h1 << 4;
    localparam logic [25:0] BA_OUT    = 26'h1 << 3;
    localparam logic [25:0] CON_IN    = 26'h1 << 2;
    localparam logic [25:0] MEM_RD    = 26'h1 << 1;
    localparam logic [25:0] MEM_WR    = 26'h1 << 0;
    localparam logic [25:0] BUS_MASK  = HI_SEL | LO_SEL | ZHI_SEL | ZLO_SEL | PC_SEL |
                                        MDR_SEL | IPORT_SEL | C_SEL | R_OUT | BA_OUT;

    typedef struct packed {
        logic [4:0]  alu;
        logic [25:0] c;
    } step_t;

    step_t       prog[$];
    logic [25:0] obs_c;
    int          checks = 0;
    int          errors = 0;

    assign obs_c = {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
                    HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel, IPortSel, CSel,
                    Gra, Grb, Grc, RIn, ROut, BAOut, ConIn, memread, memwrite};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic step_t s(input logic [25:0] c, input logic [4:0] a);
        return '{alu: a, c: c};
    endfunction

    // Expected micro-program of one instruction, fetch included; its length is the instruction length.
    task automatic build(input logic [4:0] op, input logic con_v);
        prog.delete();
        prog.push_back(s(PC_SEL | MAR_IN | Z_IN, 5'b11111));
        prog.push_back(s(MEM_RD | MDR_IN | ZLO_SEL | PC_IN, 5'd0));
        prog.push_back(s(MDR_SEL | IR_IN, 5'd0));
        if (op <= 5'd2) begin
            prog.push_back(s(GRB | BA_OUT | Y_IN, 5'd0));
            prog.push_back(s(C_SEL | Z_IN, 5'b00011));
            if (op == 5'd1) begin
                prog.push_back(s(ZLO_SEL | GRA | R_IN, 5'd0));
            end else begin
                prog.push_back(s(ZLO_SEL | MAR_IN, 5'd0));
                if (op == 5'd0) begin
                    prog.push_back(s(MEM_RD | MDR_IN, 5'd0));
                    prog.push_back(s(MDR_SEL | GRA | R_IN, 5'd0));
                end else begin
                    prog.push_back(s(GRA | R_OUT | MEM_WR, 5'd0));
                end
            end
        end else if (op <= 5'd14) begin
            prog.push_back(s(GRB | R_OUT | Y_IN, 5'd0));
            if (op <= 5'd11)       prog.push_back(s(GRC | R_OUT | Z_IN, op));
            else if (op == 5'd12)  prog.push_back(s(C_SEL | Z_IN, 5'b00011));
            else if (op == 5'd13)  prog.push_back(s(C_SEL | Z_IN, 5'b00101));
            else                   prog.push_back(s(C_SEL | Z_IN, 5'b00110));
            prog.push_back(s(ZLO_SEL | GRA | R_IN, 5'd0));
        end else if (op <= 5'd16) begin
            prog.push_back(s(GRA | R_OUT | Y_IN, 5'd0));
            prog.push_back(s(GRB | R_OUT | Z_IN, op));
            prog.push_back(s(ZLO_SEL | LO_IN, 5'd0));
            prog.push_back(s(ZHI_SEL | HI_IN, 5'd0));
        end else if (op <= 5'd18) begin
            prog.push_back(s(GRB | R_OUT | Z_IN, op));
            prog.push_back(s(ZLO_SEL | GRA | R_IN, 5'd0));
        end else begin
            case (op)
                5'd19: begin
                    prog.push_back(s(GRA | R_OUT | CON_IN, 5'd0));
                    prog.push_back(s(PC_SEL | Y_IN, 5'd0));
                    prog.push_back(s(C_SEL | Z_IN, 5'b00011));
                    prog.push_back(s(ZLO_SEL | (con_v ? PC_IN : 26'd0), 5'd0));
                end
                5'd20: begin
                    prog.push_back(s(PC_SEL | GRB | R_IN, 5'd0));
                    prog.push_back(s(GRA | R_OUT | PC_IN, 5'd0));
                end
                5'd21: prog.push_back(s(GRA | R_OUT | PC_IN, 5'd0));
                5'd22: prog.push_back(s(IPORT_SEL | GRA | R_IN, 5'd0));
                5'd23: prog.push_back(s(GRA | R_OUT | OPORT_IN, 5'd0));
                5'd24: prog.push_back(s(HI_SEL | GRA | R_IN, 5'd0));
                5'd25: prog.push_back(s(LO_SEL | GRA | R_IN, 5'd0));
                default: ;
            endcase
        end
    endtask

    task automatic check_bus(input string tag);
        check(tag, 32'($countones(obs_c & BUS_MASK) <= 1), 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic [3:0] exp_t, input logic exp_run);
        check({tag, ".tstate"}, 32'(tstate), 32'(exp_t));
        check({tag, ".ctrl"}, 32'(obs_c), 32'd0);
        check({tag, ".alu"}, 32'(ALUCode), 32'd0);
        check({tag, ".run"}, 32'(run), 32'(exp_run));
        check_bus({tag, ".bus"});
    endtask

    // Entered just after a falling edge with the DUT in T0; leaves it at the first step not run.
    task automatic run_instr(input logic [4:0] op, input logic con_v, input int max_steps);
        logic [31:0] word;
        string       tag;
        word = {op, 27'($urandom)};
        build(op, con_v);
        for (int i = 0; i < prog.size() && i < max_steps; i++) begin
            ir  = (i < 2) ? $urandom : word;
            con = (i == 6) ? con_v : 1'($urandom);
            #1;
            tag = $sformatf("op%0d.T%0d", op, i);
            check({tag, ".tstate"}, 32'(tstate), i);
            check({tag, ".ctrl"}, 32'(obs_c), 32'(prog[i].c));
            check({tag, ".alu"}, 32'(ALUCode), 32'(prog[i].alu));
            check({tag, ".run"}, 32'(run), 32'd1);
            check_bus({tag, ".bus"});
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    initial begin
        logic [4:0] dir_ops[22];
        logic [4:0] op;
        dir_ops = '{5'd3, 5'd7, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd1, 5'd2, 5'd15, 5'd16,
                    5'd17, 5'd18, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd28, 5'd31, 5'd26};

        clear = 1'b0;
        ir    = 32'hD800_0000;
        con   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check_idle("reset", 4'd8, 1'b1);

        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        run_instr(5'd26, 1'b0, 99);

        foreach (dir_ops[k]) run_instr(dir_ops[k], 1'b0, 99);
        run_instr(5'd19, 1'b1, 99);
        run_instr(5'd19, 1'b0, 99);

        for (int n = 0; n < 80; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr(op, 1'($urandom), 99);
        end

        // Clear asserted in T5 of mul must silence the outputs before any clock edge.
        run_instr(5'd16, 1'b0, 5);
        ir = {5'b10000, 27'($urandom)};
        #1;
        check("mul.T5.tstate", 32'(tstate), 32'd5);
        check("mul.T5.ctrl", 32'(obs_c), 32'(ZLO_SEL | LO_IN));
        clear = 1'b0;
        #1;
        check_idle("midclear.now", 4'd8, 1'b1);
        @(posedge clock);
        @(negedge clock);
        #1;
        check_idle("midclear.held", 4'd8, 1'b1);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        run_instr(5'd26, 1'b0, 99);

        run_instr(5'd27, 1'b0, 99);
        for (int n = 0; n < 20; n++) begin
            ir  = $urandom;
            con = 1'($urandom);
            #1;
            check_idle($sformatf("halt%0d", n), 4'd9, 1'b0);
            @(posedge clock);
            @(negedge clock);
        end
        clear = 1'b0;
        #1;
        check_idle("halt.clear", 4'd8, 1'b1);
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        run_instr(5'd3, 1'b0, 99);
        run_instr(5'd26, 1'b0, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
